// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: sequences one asynchronous SRAM read or write at a time with registered strobes
module sram_access_ctrl #(
    parameter int DW   = 16,
    parameter int AW   = 18,
    parameter int WAIT = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          ready,
    output logic          done,
    output logic          rvalid,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_dout,
    output logic          sram_doe,
    input  logic [DW-1:0] sram_din,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n
);
    typedef enum logic [2:0] {IDLE, SETUP, WR, HOLD, RD, TURN} state_t;
    state_t     state;
    logic [3:0] cnt;
    assign ready = state == IDLE;
    // Access sequencer: every strobe and bus enable is set on the transition into the state that needs it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            done      <= 1'b0;
            rvalid    <= 1'b0;
            rdata     <= '0;
            sram_addr <= '0;
            sram_dout <= '0;
            sram_doe  <= 1'b0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
        end else begin
            done   <= 1'b0;
            rvalid <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    sram_addr <= addr;
                    sram_dout <= wdata;
                    sram_ce_n <= 1'b0;
                    if (we) begin
                        state    <= SETUP;
                        sram_doe <= 1'b1;
                    end else begin
                        state     <= RD;
                        sram_oe_n <= 1'b0;
                        cnt       <= 4'(WAIT);
                    end
                end
                SETUP: begin
                    state     <= WR;
                    sram_we_n <= 1'b0;
                    cnt       <= 4'(WAIT - 1);
                end
                WR: if (cnt == 4'd0) begin
                    state     <= HOLD;
                    sram_we_n <= 1'b1;
                    done      <= 1'b1;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                HOLD: begin
                    state     <= IDLE;
                    sram_ce_n <= 1'b1;
                    sram_doe  <= 1'b0;
                end
                RD: if (cnt == 4'd0) begin
                    state     <= TURN;
                    sram_oe_n <= 1'b1;
                    sram_ce_n <= 1'b1;
                    rdata     <= sram_din;
                    rvalid    <= 1'b1;
                    done      <= 1'b1;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                TURN: state <= IDLE;
                default: begin
                    state     <= IDLE;
                    sram_doe  <= 1'b0;
                    sram_ce_n <= 1'b1;
                    sram_oe_n <= 1'b1;
                    sram_we_n <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb_sram_access_ctrl: three controllers (WAIT=2,1,15) against a timeline model and an SRAM device model
module tb_sram_access_ctrl;
    localparam int WS [3] = '{2, 1, 15};
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req [3];
    logic        we [3];
    logic [17:0] addr [3];
    logic [15:0] wdata [3];
    logic        ready [3];
    logic        done [3];
    logic        rvalid [3];
    logic [15:0] rdata [3];
    logic [17:0] sram_addr [3];
    logic [15:0] sram_dout [3];
    logic        sram_doe [3];
    logic [15:0] sram_din [3];
    logic        ce_n [3];
    logic        oe_n [3];
    logic        we_n [3];
    logic [15:0] dev_mem [3][256];
    logic [15:0] ref_mem [3][256];
    int          t [3];
    logic        m_we [3];
    logic [17:0] m_addr [3];
    logic [15:0] m_wdata [3];
    logic [15:0] m_exp [3];
    logic [15:0] m_rdata [3];
    int          cyc = 0;
    int          done_cnt [3] = '{0, 0, 0};
    int          last_done [3] = '{0, 0, 0};
    int          prev_done [3] = '{0, 0, 0};
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sram_access_ctrl #(.DW(16), .AW(18), .WAIT(WS[g])) u_dut (
            .clk(clk), .reset_n(reset_n), .req(req[g]), .we(we[g]), .addr(addr[g]), .wdata(wdata[g]),
            .ready(ready[g]), .done(done[g]), .rvalid(rvalid[g]), .rdata(rdata[g]),
            .sram_addr(sram_addr[g]), .sram_dout(sram_dout[g]), .sram_doe(sram_doe[g]), .sram_din(sram_din[g]),
            .sram_ce_n(ce_n[g]), .sram_oe_n(oe_n[g]), .sram_we_n(we_n[g])
        );
    end

    function automatic logic [15:0] init_val(int a);
        logic [7:0] x;
        x = 8'(a) ^ 8'h10;
        return {x, x} ^ 16'h5AA5;
    endfunction

    // Device: drives stored data while selected and output-enabled, stores while write-strobed
    always_comb begin
        for (int i = 0; i < 3; i++)
            sram_din[i] = (!ce_n[i] && !oe_n[i]) ? dev_mem[i][sram_addr[i][7:0]] : 16'hDEAD;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset_n)
                for (int a = 0; a < 256; a++) dev_mem[i][a] <= init_val(a);
            else if (!ce_n[i] && !we_n[i] && sram_doe[i])
                dev_mem[i][sram_addr[i][7:0]] <= sram_dout[i];
        end
    end

    // Reference model: t counts cycles since accept (0 = idle), memory updated at accept
    always @(posedge clk or negedge reset_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset_n) begin
                t[i]       <= 0;
                m_addr[i]  <= '0;
                m_rdata[i] <= '0;
                for (int a = 0; a < 256; a++) ref_mem[i][a] <= init_val(a);
            end else if (t[i] == 0) begin
                if (req[i]) begin
                    t[i]       <= 1;
                    m_we[i]    <= we[i];
                    m_addr[i]  <= addr[i];
                    m_wdata[i] <= wdata[i];
                    if (we[i]) ref_mem[i][addr[i][7:0]] <= wdata[i];
                    else m_exp[i] <= ref_mem[i][addr[i][7:0]];
                end
            end else if (t[i] == WS[i] + 2) begin
                t[i] <= 0;
            end else begin
                t[i] <= t[i] + 1;
                if (t[i] == WS[i] + 1 && !m_we[i]) m_rdata[i] <= m_exp[i];
            end
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++)
            if (done[i]) begin
                done_cnt[i]  <= done_cnt[i] + 1;
                prev_done[i] <= last_done[i];
                last_done[i] <= cyc;
            end
    end

    task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] at cycle %0d: got %0h expected %0h", name, i, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison of every output against the model timeline
    initial forever begin
        @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++) begin
            automatic int  w  = WS[i];
            automatic bit  bz = t[i] != 0;
            automatic bit  wr = bz && m_we[i];
            automatic bit  rd = bz && !m_we[i];
            chk("ready", i, 32'(ready[i]), 32'(!bz));
            chk("ce_n", i, 32'(ce_n[i]), 32'(!(wr ? t[i] <= w + 2 : rd && t[i] <= w + 1)));
            chk("doe", i, 32'(sram_doe[i]), 32'(wr));
            chk("we_n", i, 32'(we_n[i]), 32'(!(wr && t[i] >= 2 && t[i] <= w + 1)));
            chk("oe_n", i, 32'(oe_n[i]), 32'(!(rd && t[i] <= w + 1)));
            chk("done", i, 32'(done[i]), 32'(bz && t[i] == w + 2));
            chk("rvalid", i, 32'(rvalid[i]), 32'(rd && t[i] == w + 2));
            chk("rdata", i, 32'(rdata[i]), 32'(m_rdata[i]));
            chk("sram_addr", i, 32'(sram_addr[i]), 32'(m_addr[i]));
            if (wr) chk("sram_dout", i, 32'(sram_dout[i]), 32'(m_wdata[i]));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Presents a request, waits for acceptance, returns 1 time unit after the accepting edge
    task automatic issue(int i, logic w, logic [17:0] a, logic [15:0] d, bit hold);
        int n;
        n = 0;
        @(negedge clk);
        req[i] = 1'b1;
        we[i] = w;
        addr[i] = a;
        wdata[i] = d;
        while (!ready[i] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            errors++;
            $display("FAIL accept_timeout[%0d]: ready stayed 0 for %0d cycles", i, n);
        end
        @(posedge clk);
        #1;
        if (!hold) req[i] = 1'b0;
    endtask

    initial begin
        int dc;
        logic [15:0] p;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0;
            we[i] = 1'b0;
            addr[i] = '0;
            wdata[i] = '0;
        end
        repeat (3) step();
        chk("rst_ready", 0, 32'(ready[0]), 32'd1);
        chk("rst_ce_n", 0, 32'(ce_n[0]), 32'd1);
        chk("rst_doe", 0, 32'(sram_doe[0]), 32'd0);
        chk("rst_rdata", 0, 32'(rdata[0]), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        issue(0, 1'b1, 18'h12345, 16'hA5C3, 1'b0);
        #1;
        chk("w_k1_doe", 0, 32'(sram_doe[0]), 32'd1);
        chk("w_k1_we_n", 0, 32'(we_n[0]), 32'd1);
        chk("w_k1_addr", 0, 32'(sram_addr[0]), 32'h12345);
        step();
        chk("w_k2_we_n", 0, 32'(we_n[0]), 32'd0);
        step();
        chk("w_k3_we_n", 0, 32'(we_n[0]), 32'd0);
        step();
        chk("w_k4_done", 0, 32'(done[0]), 32'd1);
        chk("w_k4_we_n", 0, 32'(we_n[0]), 32'd1);
        chk("w_k4_dout", 0, 32'(sram_dout[0]), 32'hA5C3);
        step();
        chk("w_k5_doe", 0, 32'(sram_doe[0]), 32'd0);
        chk("w_k5_ready", 0, 32'(ready[0]), 32'd1);

        issue(0, 1'b0, 18'h00010, 16'h0000, 1'b0);
        #1;
        chk("r_k1_oe_n", 0, 32'(oe_n[0]), 32'd0);
        step();
        step();
        chk("r_k3_oe_n", 0, 32'(oe_n[0]), 32'd0);
        step();
        chk("r_k4_rvalid", 0, 32'(rvalid[0]), 32'd1);
        chk("r_k4_rdata", 0, 32'(rdata[0]), 32'h5AA5);
        chk("r_k4_oe_n", 0, 32'(oe_n[0]), 32'd1);
        step();
        chk("r_k5_ready", 0, 32'(ready[0]), 32'd1);

        issue(0, 1'b0, 18'h00011, 16'h0000, 1'b1);
        we[0] = 1'b1;
        addr[0] = 18'h00022;
        wdata[0] = 16'hBEEF;
        #1;
        for (int j = 1; j <= 4; j++) begin
            chk("b2b_doe_rd", j, 32'(sram_doe[0]), 32'd0);
            step();
        end
        chk("b2b_k5_ready", 0, 32'(ready[0]), 32'd1);
        chk("b2b_k5_doe", 0, 32'(sram_doe[0]), 32'd0);
        step();
        req[0] = 1'b0;
        chk("b2b_k6_doe", 0, 32'(sram_doe[0]), 32'd1);
        chk("b2b_k6_addr", 0, 32'(sram_addr[0]), 32'h00022);
        repeat (5) step();

        dc = done_cnt[0];
        issue(0, 1'b1, 18'h00055, 16'h0F0F, 1'b0);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            req[0] = (j % 2 == 0);
        end
        repeat (4) step();
        chk("toggle_dones", 0, 32'(done_cnt[0]), 32'(dc + 1));
        issue(0, 1'b0, 18'h00055, 16'h0000, 1'b0);
        #1;
        repeat (3) step();
        chk("toggle_rdata", 0, 32'(rdata[0]), 32'h0F0F);
        step();

        dc = done_cnt[0];
        issue(0, 1'b1, 18'h00077, 16'h1234, 1'b0);
        #1;
        step();
        chk("mid_we_n_pre", 0, 32'(we_n[0]), 32'd0);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_we_n", 0, 32'(we_n[0]), 32'd1);
        chk("mid_ce_n", 0, 32'(ce_n[0]), 32'd1);
        chk("mid_doe", 0, 32'(sram_doe[0]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) step();
        chk("mid_ready", 0, 32'(ready[0]), 32'd1);
        chk("mid_no_done", 0, 32'(done_cnt[0]), 32'(dc));

        for (int i = 1; i < 3; i++) begin
            issue(i, 1'b1, 18'h00040, 16'h1111, 1'b1);
            issue(i, 1'b1, 18'h00041, 16'h2222, 1'b0);
            repeat (WS[i] + 3) step();
            chk("wr_period", i, 32'(last_done[i] - prev_done[i]), i == 1 ? 32'd4 : 32'd18);
            issue(i, 1'b0, 18'h00040, 16'h0000, 1'b1);
            issue(i, 1'b0, 18'h00041, 16'h0000, 1'b0);
            repeat (WS[i] + 3) step();
            chk("rd_period", i, 32'(last_done[i] - prev_done[i]), i == 1 ? 32'd4 : 32'd18);
            chk("rd_period_data", i, 32'(rdata[i]), 32'h2222);
            for (int j = 0; j < 18; j++) begin
                p = (j == 0) ? 16'h0000 : (j == 1) ? 16'hFFFF : 16'(1 << (j - 2));
                issue(i, 1'b1, 18'(32 + j), p, 1'b0);
                issue(i, 1'b0, 18'(32 + j), 16'h0000, 1'b0);
                #1;
                repeat (WS[i] + 1) step();
                chk("rt_rvalid", i, 32'(rvalid[i]), 32'd1);
                chk("rt_rdata", i, 32'(rdata[i]), 32'(p));
            end
        end
        repeat (4) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
